// File: rtl/cga_pkg.sv
// Shared definitions for the CGA palette controller: port
// addresses, phase/state enums and the default CGA palette.
package cga_pkg;

    localparam logic [1:0] ADDR_WR_IDX = 2'd0;
    localparam logic [1:0] ADDR_DATA   = 2'd1;
    localparam logic [1:0] ADDR_RD_IDX = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    typedef enum logic [1:0] {
        PH_R = 2'd0,
        PH_G = 2'd1,
        PH_B = 2'd2
    } phase_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Entry i is CGA_DEFAULT_PALETTE[i], packed {R,G,B}.
    localparam logic [15:0][17:0] CGA_DEFAULT_PALETTE = {
        {6'h3F, 6'h3F, 6'h3F},
        {6'h3F, 6'h3F, 6'h15},
        {6'h3F, 6'h15, 6'h3F},
        {6'h3F, 6'h15, 6'h15},
        {6'h15, 6'h3F, 6'h3F},
        {6'h15, 6'h3F, 6'h15},
        {6'h15, 6'h15, 6'h3F},
        {6'h15, 6'h15, 6'h15},
        {6'h2A, 6'h2A, 6'h2A},
        {6'h2A, 6'h15, 6'h00},
        {6'h2A, 6'h00, 6'h2A},
        {6'h2A, 6'h00, 6'h00},
        {6'h00, 6'h2A, 6'h2A},
        {6'h00, 6'h2A, 6'h00},
        {6'h00, 6'h00, 6'h2A},
        {6'h00, 6'h00, 6'h00}
    };

    function automatic logic [5:0] comp_sel(
        input logic [17:0] e,
        input phase_t      ph
    );
        case (ph)
            PH_R:    return e[17:12];
            PH_G:    return e[11:6];
            default: return e[5:0];
        endcase
    endfunction

endpackage

// File: rtl/cga_palette_ctrl_if.sv
// CPU port of the palette controller.
// master = CPU side, slave = palette controller side.
interface cga_palette_ctrl_if;

    logic       bus_cs;
    logic       bus_wr;
    logic       bus_rd;
    logic [1:0] bus_addr;
    logic [7:0] bus_din;
    logic [7:0] bus_dout;
    logic       bus_wait;

    modport master (
        output bus_cs, bus_wr, bus_rd, bus_addr, bus_din,
        input  bus_dout, bus_wait
    );

    modport slave (
        input  bus_cs, bus_wr, bus_rd, bus_addr, bus_din,
        output bus_dout, bus_wait
    );

endinterface

// File: rtl/cga_palette_regfile.sv
// 16 x 18-bit palette storage: one synchronous write port,
// asynchronous pixel and CPU read ports.
module cga_palette_regfile (
    input  logic        clk,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [17:0] wdata,
    input  logic [3:0]  pix_addr,
    output logic [17:0] pix_data,
    input  logic [3:0]  cpu_addr,
    output logic [17:0] cpu_data
);

    // Contents need no reset: INIT rewrites every entry.
    logic [17:0] mem [16];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign pix_data = mem[pix_addr];
    assign cpu_data = mem[cpu_addr];

endmodule

// File: rtl/cga_palette_ctrl.sv
// Programmable 16-entry CGA palette with DAC-style CPU port.
// Ports: clk, rst_n, bus (CPU slave), video/video_blank in, RGB out.
module cga_palette_ctrl
    import cga_pkg::*;
#(
    parameter bit G_LSB           = 1'b1,
    parameter bit COMMIT_IN_BLANK = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    cga_palette_ctrl_if.slave  bus,
    input  logic [3:0]         video,
    input  logic               video_blank,
    output logic [5:0]         red,
    output logic [6:0]         green,
    output logic [5:0]         blue
);

    state_t      state;
    logic [3:0]  init_cnt;
    logic [3:0]  mask;
    logic [3:0]  wr_idx;
    logic [3:0]  rd_idx;
    phase_t      wr_phase;
    phase_t      rd_phase;
    logic [5:0]  buf_r;
    logic [5:0]  buf_g;
    logic        pend_valid;
    logic [17:0] pend_rgb;
    logic [3:0]  pend_idx;

    logic        in_init;
    logic        commit;
    logic        wr_req;
    logic        rd_req;
    logic        stall;
    logic        wr_go;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [17:0] rf_wdata;
    logic [17:0] pix_data;
    logic [17:0] cpu_data;
    logic        unused_din;

    assign unused_din = ^bus.bus_din[7:6];

    assign in_init = (state == ST_INIT);
    assign commit  = pend_valid &
                     (video_blank | ~COMMIT_IN_BLANK);
    assign wr_req  = bus.bus_cs & bus.bus_wr;
    assign rd_req  = bus.bus_cs & bus.bus_rd;

    // A third component can only be taken if the pending
    // slot frees up in this same cycle.
    assign stall = wr_req &
                   (in_init |
                    ((bus.bus_addr == ADDR_DATA) &
                     (wr_phase == PH_B) &
                     pend_valid & ~commit));

    assign bus.bus_wait = stall;
    assign wr_go        = wr_req & ~stall;

    assign rf_we    = in_init | commit;
    assign rf_waddr = in_init ? init_cnt : pend_idx;
    assign rf_wdata = in_init ? CGA_DEFAULT_PALETTE[init_cnt]
                              : pend_rgb;

    cga_palette_regfile u_regfile (
        .clk      (clk),
        .we       (rf_we),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .pix_addr (video & mask),
        .pix_data (pix_data),
        .cpu_addr (rd_idx),
        .cpu_data (cpu_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_INIT;
            init_cnt     <= 4'd0;
            mask         <= 4'hF;
            wr_idx       <= 4'd0;
            rd_idx       <= 4'd0;
            wr_phase     <= PH_R;
            rd_phase     <= PH_R;
            buf_r        <= 6'd0;
            buf_g        <= 6'd0;
            pend_valid   <= 1'b0;
            pend_rgb     <= 18'd0;
            pend_idx     <= 4'd0;
            bus.bus_dout <= 8'd0;
            red          <= 6'd0;
            green        <= {6'd0, G_LSB};
            blue         <= 6'd0;
        end else begin
            if (in_init) begin
                init_cnt <= init_cnt + 4'd1;
                if (init_cnt == 4'd15) begin
                    state <= ST_RUN;
                end
            end

            if (commit) begin
                pend_valid <= 1'b0;
            end

            if (rd_req) begin
                if (in_init) begin
                    bus.bus_dout <= 8'd0;
                end else begin
                    case (bus.bus_addr)
                        ADDR_WR_IDX: bus.bus_dout <= {4'd0, wr_idx};
                        ADDR_DATA: begin
                            bus.bus_dout <=
                                {2'b00, comp_sel(cpu_data, rd_phase)};
                            if (rd_phase == PH_B) begin
                                rd_phase <= PH_R;
                                rd_idx   <= rd_idx + 4'd1;
                            end else begin
                                rd_phase <= phase_t'(rd_phase + 2'd1);
                            end
                        end
                        ADDR_RD_IDX: bus.bus_dout <= {4'd0, rd_idx};
                        default: bus.bus_dout <=
                            {pend_valid, 1'b0, wr_phase, mask};
                    endcase
                end
            end

            // Index writes come after the read so they take
            // priority on a combined strobe.
            if (wr_go) begin
                case (bus.bus_addr)
                    ADDR_WR_IDX: begin
                        wr_idx   <= bus.bus_din[3:0];
                        wr_phase <= PH_R;
                    end
                    ADDR_DATA: begin
                        case (wr_phase)
                            PH_R: begin
                                buf_r    <= bus.bus_din[5:0];
                                wr_phase <= PH_G;
                            end
                            PH_G: begin
                                buf_g    <= bus.bus_din[5:0];
                                wr_phase <= PH_B;
                            end
                            PH_B: begin
                                pend_rgb   <= {buf_r, buf_g,
                                               bus.bus_din[5:0]};
                                pend_idx   <= wr_idx;
                                pend_valid <= 1'b1;
                                wr_phase   <= PH_R;
                                wr_idx     <= wr_idx + 4'd1;
                            end
                            default: wr_phase <= PH_R;
                        endcase
                    end
                    ADDR_RD_IDX: begin
                        rd_idx   <= bus.bus_din[3:0];
                        rd_phase <= PH_R;
                    end
                    default: mask <= bus.bus_din[3:0];
                endcase
            end

            if (in_init | video_blank) begin
                red   <= 6'd0;
                green <= {6'd0, G_LSB};
                blue  <= 6'd0;
            end else begin
                red   <= pix_data[17:12];
                green <= {pix_data[11:6], G_LSB};
                blue  <= pix_data[5:0];
            end
        end
    end

endmodule

// File: tb/tb_cga_palette_ctrl.sv
// Self-checking bench for cga_palette_ctrl against a
// behavioural palette model.
module tb_cga_palette_ctrl;

    localparam bit GL = 1'b1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] video = 4'd0;
    logic       video_blank = 1'b1;
    logic [5:0] red;
    logic [6:0] green;
    logic [5:0] blue;

    int checks = 0;
    int errors = 0;

    logic [17:0] m_pal [16];
    logic [3:0]  m_mask;

    cga_palette_ctrl_if bus ();

    cga_palette_ctrl #(
        .G_LSB           (GL),
        .COMMIT_IN_BLANK (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .video       (video),
        .video_blank (video_blank),
        .red         (red),
        .green       (green),
        .blue        (blue)
    );

    always #5 clk = ~clk;

    // Standard CGA rule: low-intensity amplitude 2A per bit,
    // high-intensity adds 15 to all, colour 6 has green 15.
    function automatic logic [17:0] def_rgb(input int i);
        int hi, r, g, b;
        hi = (i >= 8) ? 'h15 : 0;
        r  = hi + (((i & 4) != 0) ? 'h2A : 0);
        g  = hi + (((i & 2) != 0) ? 'h2A : 0);
        b  = hi + (((i & 1) != 0) ? 'h2A : 0);
        if (i == 6) g = 'h15;
        return {r[5:0], g[5:0], b[5:0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_pal[i] = def_rgb(i);
        m_mask = 4'hF;
    endtask

    task automatic bus_write(input logic [1:0] a,
                             input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        bus.bus_cs = 1'b1; bus.bus_wr = 1'b1;
        bus.bus_addr = a; bus.bus_din = d;
        #1;
        while (bus.bus_wait === 1'b1 && n < 100) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL write_timeout addr=%0d", a);
        end
        @(posedge clk); #1;
        bus.bus_cs = 1'b0; bus.bus_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a,
                            output logic [7:0] d);
        @(negedge clk);
        bus.bus_cs = 1'b1; bus.bus_rd = 1'b1; bus.bus_addr = a;
        @(posedge clk); #1;
        bus.bus_cs = 1'b0; bus.bus_rd = 1'b0;
        d = bus.bus_dout;
    endtask

    task automatic write_entry(input logic [3:0] idx,
                               input logic [17:0] rgb);
        video_blank = 1'b1;
        bus_write(2'd0, {4'd0, idx});
        bus_write(2'd1, {2'd0, rgb[17:12]});
        bus_write(2'd1, {2'd0, rgb[11:6]});
        bus_write(2'd1, {2'd0, rgb[5:0]});
        @(posedge clk); #1;
        m_pal[idx] = rgb;
    endtask

    task automatic check_pixel(input logic [3:0] v,
                               input string name);
        logic [17:0] e;
        logic [18:0] got, exp;
        @(negedge clk);
        video = v; video_blank = 1'b0;
        @(posedge clk); #1;
        e   = m_pal[v & m_mask];
        exp = {e[17:12], e[11:6], GL, e[5:0]};
        got = {red, green, blue};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s v=%h got=%h exp=%h", name, v, got, exp);
        end
    endtask

    task automatic check_byte(input logic [7:0] got,
                              input logic [7:0] exp,
                              input string name);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_zero_rgb(input string name);
        checks++;
        if (red !== 6'd0 || green !== {6'd0, GL} || blue !== 6'd0) begin
            errors++;
            $display("FAIL %s got=%h/%h/%h exp=00/%h/00",
                     name, red, green, blue, {6'd0, GL});
        end
    endtask

    // Release reset and count cycles until a held write is accepted.
    task automatic wait_init(input string name);
        int n = 0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.bus_cs = 1'b1; bus.bus_wr = 1'b1;
        bus.bus_addr = 2'd3; bus.bus_din = 8'h0F;
        #1;
        while (bus.bus_wait === 1'b1 && n < 40) begin
            @(negedge clk); #1; n++;
            if (n == 8) check_zero_rgb({name, "_init_rgb"});
        end
        @(posedge clk); #1;
        bus.bus_cs = 1'b0; bus.bus_wr = 1'b0;
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL %s_init_len got=%0d exp=16", name, n);
        end
        model_reset();
    endtask

    task automatic test_reset();
        logic [7:0] d;
        video = 4'd6; video_blank = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_rgb("reset_rgb");
        check_byte(bus.bus_dout, 8'h00, "reset_dout");
        wait_init("reset");
        bus_read(2'd3, d);
        check_byte(d, 8'h0F, "status_after_init");
        check_pixel(4'd6, "brown_after_init");
    endtask

    task automatic test_default();
        for (int i = 0; i < 16; i++) check_pixel(i[3:0], "default");
        @(negedge clk);
        video = 4'd7; video_blank = 1'b1;
        @(posedge clk); #1;
        check_zero_rgb("blank_rgb");
    endtask

    task automatic test_read();
        logic [7:0] d;
        logic [17:0] e9, e10;
        e9 = m_pal[9]; e10 = m_pal[10];
        bus_write(2'd2, 8'd9);
        bus_read(2'd1, d); check_byte(d, {2'd0, e9[17:12]}, "rd9_r");
        bus_read(2'd1, d); check_byte(d, {2'd0, e9[11:6]}, "rd9_g");
        bus_read(2'd1, d); check_byte(d, {2'd0, e9[5:0]}, "rd9_b");
        bus_read(2'd1, d); check_byte(d, {2'd0, e10[17:12]}, "rd10_r");
        bus_read(2'd2, d); check_byte(d, 8'd10, "rd_idx");
    endtask

    task automatic test_pending_hold();
        logic [7:0] d;
        @(negedge clk); video_blank = 1'b0;
        bus_write(2'd0, 8'd3);
        bus_write(2'd1, 8'h3F);
        bus_write(2'd1, 8'h00);
        bus_write(2'd1, 8'h00);
        bus_read(2'd3, d);
        check_byte(d, 8'h8F, "status_pending");
        check_pixel(4'd3, "pending_not_visible");
        @(negedge clk); video_blank = 1'b1;
        @(posedge clk); #1;
        m_pal[3] = {6'h3F, 6'h00, 6'h00};
        check_pixel(4'd3, "after_commit");
        bus_read(2'd3, d);
        check_byte(d, 8'h0F, "status_committed");
    endtask

    task automatic test_wrap();
        logic [7:0] d;
        logic [17:0] a, b;
        a = 18'($urandom); b = 18'($urandom);
        video_blank = 1'b1;
        bus_write(2'd0, 8'd15);
        bus_write(2'd1, {2'd0, a[17:12]});
        bus_write(2'd1, {2'd0, a[11:6]});
        bus_write(2'd1, {2'd0, a[5:0]});
        bus_write(2'd1, {2'd0, b[17:12]});
        bus_write(2'd1, {2'd0, b[11:6]});
        bus_write(2'd1, {2'd0, b[5:0]});
        @(posedge clk); #1;
        m_pal[15] = a; m_pal[0] = b;
        bus_read(2'd3, d);
        check_byte(d, 8'h0F, "wrap_status");
        bus_read(2'd0, d);
        check_byte(d, 8'd1, "wrap_wr_idx");
        check_pixel(4'd15, "wrap_e15");
        check_pixel(4'd0, "wrap_e0");
    endtask

    task automatic test_stall();
        logic [7:0] d;
        logic [17:0] a, b;
        a = 18'($urandom); b = 18'($urandom);
        @(negedge clk); video_blank = 1'b0;
        bus_write(2'd0, 8'd5);
        bus_write(2'd1, {2'd0, a[17:12]});
        bus_write(2'd1, {2'd0, a[11:6]});
        bus_write(2'd1, {2'd0, a[5:0]});
        bus_write(2'd1, {2'd0, b[17:12]});
        bus_write(2'd1, {2'd0, b[11:6]});
        @(negedge clk);
        bus.bus_cs = 1'b1; bus.bus_wr = 1'b1;
        bus.bus_addr = 2'd1; bus.bus_din = {2'd0, b[5:0]};
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus.bus_wait !== 1'b1) begin
                errors++;
                $display("FAIL stall_wait k=%0d got=%b exp=1",
                         k, bus.bus_wait);
            end
            @(negedge clk); #1;
        end
        video_blank = 1'b1;
        #1;
        checks++;
        if (bus.bus_wait !== 1'b0) begin
            errors++;
            $display("FAIL stall_release got=%b exp=0", bus.bus_wait);
        end
        @(posedge clk); #1;
        bus.bus_cs = 1'b0; bus.bus_wr = 1'b0;
        bus_read(2'd3, d);
        check_byte(d, 8'h8F, "stall_new_pending");
        bus_read(2'd3, d);
        check_byte(d, 8'h0F, "stall_drained");
        m_pal[5] = a; m_pal[6] = b;
        check_pixel(4'd5, "stall_e5");
        check_pixel(4'd6, "stall_e6");
    endtask

    task automatic test_mask();
        bus_write(2'd3, 8'h03);
        m_mask = 4'h3;
        check_pixel(4'hF, "mask_f");
        for (int i = 0; i < 4; i++)
            check_pixel(4'($urandom), "mask_rand");
        bus_write(2'd3, 8'h0F);
        m_mask = 4'hF;
    endtask

    task automatic test_random();
        logic [7:0]  d;
        logic [3:0]  idx;
        logic [17:0] rgb;
        for (int it = 0; it < 20; it++) begin
            idx = 4'($urandom_range(0, 15));
            rgb = 18'($urandom);
            write_entry(idx, rgb);
            bus_write(2'd2, {4'd0, idx});
            bus_read(2'd1, d);
            check_byte(d, {2'd0, m_pal[idx][17:12]}, "rand_rd_r");
            bus_read(2'd1, d);
            check_byte(d, {2'd0, m_pal[idx][11:6]}, "rand_rd_g");
            bus_read(2'd1, d);
            check_byte(d, {2'd0, m_pal[idx][5:0]}, "rand_rd_b");
            check_pixel(idx, "rand_pix_idx");
            check_pixel(4'($urandom), "rand_pix_any");
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        video_blank = 1'b1;
        bus_write(2'd3, 8'h05);
        bus_write(2'd0, 8'd2);
        bus_write(2'd1, 8'h11);
        bus_write(2'd1, 8'h22);
        @(negedge clk);
        video = 4'd3; video_blank = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero_rgb("midreset_rgb");
        check_byte(bus.bus_dout, 8'h00, "midreset_dout");
        wait_init("midreset");
        bus_read(2'd3, d);
        check_byte(d, 8'h0F, "midreset_status");
        bus_read(2'd0, d);
        check_byte(d, 8'h00, "midreset_wr_idx");
        check_pixel(4'd2, "midreset_e2");
        check_pixel(4'd3, "midreset_e3");
        check_pixel(4'hD, "midreset_ed");
    endtask

    initial begin
        bus.bus_cs = 1'b0; bus.bus_wr = 1'b0; bus.bus_rd = 1'b0;
        bus.bus_addr = 2'd0; bus.bus_din = 8'd0;
        model_reset();
        test_reset();
        test_default();
        test_read();
        test_pending_hold();
        test_wrap();
        test_stall();
        test_mask();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
